// File: rtl/datapath_ctrl.sv
// datapath_ctrl: expands one 8-bit instruction into the multi-cycle control sequence of the 4-register datapath.
// Optional build macro DATAPATH_CTRL_TRAP_EN: illegal opcodes trap into HALT and raise err instead of acting as a NOP.
module datapath_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [7:0] instr,
    output logic [1:0] sr,
    output logic [1:0] Rn,
    output logic       w,
    output logic [1:0] aluop,
    output logic       lt,
    output logic [2:0] tsel,
    output logic [2:0] bsel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADT = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic [2:0] op_q;
    logic [1:0] rd_q;
    logic [1:0] rs_q;
    logic [1:0] tsrc;

    // instr[0] carries no meaning in the instruction format
    logic unused_instr_lsb;
    assign unused_instr_lsb = instr[0];

    function automatic logic [2:0] reg_onehot(input logic [1:0] idx);
        case (idx)
            2'd1:    reg_onehot = 3'b001;
            2'd2:    reg_onehot = 3'b010;
            2'd3:    reg_onehot = 3'b100;
            default: reg_onehot = 3'b000;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        op_legal = (op <= OP_SHL);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= 3'b000;
            rd_q  <= 2'b00;
            rs_q  <= 2'b00;
        end else begin
            state <= state_nx;
            if (state == IDLE && s) begin
                op_q <= instr[7:5];
                rd_q <= instr[4:3];
                rs_q <= instr[2:1];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (s) begin
                    if (instr[7:5] == OP_LDI)
                        state_nx = WRITE;
                    else if (op_legal(instr[7:5]))
                        state_nx = LOADT;
                    else
`ifdef DATAPATH_CTRL_TRAP_EN
                        state_nx = HALT;
`else
                        state_nx = DONE;
`endif
                end
            end
            LOADT:   state_nx = WRITE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    // Moore decode: MOV copies Rs through tmp, the ALU ops preload tmp with Rd
    always_comb begin
        sr    = 2'b00;
        Rn    = 2'b00;
        w     = 1'b0;
        aluop = 2'b00;
        lt    = 1'b0;
        tsel  = 3'b000;
        bsel  = 3'b000;
        busy  = 1'b0;
        done  = 1'b0;
        tsrc  = (op_q == OP_MOV) ? rs_q : rd_q;
        case (state)
            LOADT: begin
                busy = 1'b1;
                lt   = 1'b1;
                if (tsrc == 2'd0) begin
                    tsel = 3'b010;
                end else begin
                    tsel = 3'b100;
                    bsel = reg_onehot(tsrc);
                end
            end
            WRITE: begin
                busy = 1'b1;
                w    = 1'b1;
                Rn   = rd_q;
                case (op_q)
                    OP_LDI: sr = 2'b00;
                    OP_MOV: sr = 2'b10;
                    OP_XOR: begin sr = 2'b01; aluop = 2'b00; bsel = reg_onehot(rs_q); end
                    OP_AND: begin sr = 2'b01; aluop = 2'b01; bsel = reg_onehot(rs_q); end
                    OP_SHL: begin sr = 2'b01; aluop = 2'b10; bsel = reg_onehot(rs_q); end
                    default: w = 1'b0;
                endcase
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

`ifdef DATAPATH_CTRL_TRAP_EN
    // sticky trap flag, raised together with entry into HALT
    logic err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (state_nx == HALT)
            err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Sequencing controller that drives the control port of the 8-bit four-register datapath (R0–R3 register file, tmp register, XOR/AND/SHL/pass ALU). It accepts one 8-bit instruction at a time through a start/done handshake and expands it into the multi-cycle sequence of `sr`, `Rn`, `w`, `aluop`, `lt`, `tsel` and `bsel` values the datapath consumes. It sits directly above the datapath; its outputs connect one-to-one to the datapath's control inputs.

## Interface
- No parameters; widths are fixed by the datapath control port.
- `clk`  in  1  datapath clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- `s`  in  1  start; sampled only in IDLE.
- `instr`  in  8  instruction fields: `[7:5]` op, `[4:3]` rd, `[2:1]` rs, `[0]` ignored.
- `sr`  out  2  register-write source: 00 = external `in`, 01 = ALU result, 10 = tmp.
- `Rn`  out  2  destination register index.
- `w`  out  1  register-file write enable.
- `aluop`  out  2  00 = tmp^B, 01 = tmp&B, 10 = tmp<<1, 11 = B.
- `lt`  out  1  tmp load enable.
- `tsel`  out  3  one-hot tmp source: 001 = ALU, 010 = R0, 100 = B.
- `bsel`  out  3  one-hot B operand: 001 = R1, 010 = R2, 100 = R3, 000 = zero.
- `busy`  out  1  high from the cycle after acceptance through the WRITE state.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  illegal-opcode flag (see Configuration).

## Operation
- Opcodes:
  - 000 LDI: Rd ← `in`.
  - 001 MOV: Rd ← Rs.
  - 010 XOR: Rd ← Rd ^ Rs.
  - 011 AND: Rd ← Rd & Rs.
  - 100 SHL: Rd ← Rd << 1, zero fill, MSB discarded.
  - 101–111 illegal.
- FSM states: IDLE, LOADT, WRITE, DONE, and HALT (macro only).
- IDLE: all control outputs 0. If `s`=1, latch `instr` and go to WRITE for LDI, LOADT for other legal ops, or the illegal path.
- LOADT: `lt`=1.
  - Source is Rs for MOV and Rd for XOR, AND and SHL.
  - Index 0 selects `tsel`=010, `bsel`=000.
  - Index k = 1..3 selects `tsel`=100, `bsel`=one-hot(k).
  - Always goes to WRITE.
- WRITE: `w`=1, `Rn`=rd.
  - LDI: `sr`=00.
  - MOV: `sr`=10.
  - XOR, AND, SHL: `sr`=01, `aluop` per op, `bsel`=one-hot(rs) or 000 when rs=0.
  - XOR/AND with rs=0 use B=0: Rd^0 = Rd, Rd&0 = 0.
  - Always goes to DONE.
- DONE: `done`=1, all other control outputs 0. Always goes to IDLE.
- Outputs are Moore, decoded from the state and the latched instruction only.
- `s` while not in IDLE, including DONE, is ignored and not queued.
- `instr` changes after acceptance have no effect.

## Timing
- Reset value of every output is 0; state is IDLE; the latched instruction is 0. `err` clears only on reset.
- Let E0 be the edge that samples `s`=1.
  - ALU, MOV and SHL ops: tmp loads at E1, Rd writes at E2, `done` is high in the cycle after E2, back in IDLE at E3.
  - LDI: Rd writes at E1, `done` is high after E1, back in IDLE at E2.
- `in` must be stable during the LDI WRITE cycle.
- rd = rs is legal. tmp holds the pre-write value, so XOR Rd,Rd gives 0.
- Reset asserted mid-operation immediately forces all control outputs to 0 and abandons any write not yet clocked.
- `s` held high continuously starts a new instruction on each return to IDLE: ALU ops every 4 cycles, LDI every 3.

## Configuration
- `DATAPATH_CTRL_TRAP_EN` defined: an illegal op goes from IDLE to HALT, which sets `err`=1 and drives all control outputs 0. HALT is never left except by reset, and `done` is never pulsed.
- Not defined: an illegal op goes IDLE → DONE as a NOP. `done` pulses, no register changes, and `err` is tied to 0.

## Test plan
- Reset mid-WRITE of XOR → outputs all 0 immediately, state IDLE, target register unchanged; the next LDI works normally.
- LDI R1 with `in`=8'h5A, then MOV R0,R1 → `out` (R0) = 8'h5A. `done` pulses 2 and 3 cycles after their respective starts.
- R2=8'hF0, R3=8'h3C, XOR R2,R3 → R2=8'hCC. Then AND R2,R3 → R2=8'h0C.
- R1=8'h81, SHL R1 → R1=8'h02. Then XOR R1,R1 → R1=8'h00.
- `s` pulsed during LOADT and DONE → ignored; only one `done` per accepted instruction. `s` held high → back-to-back ops at 4-cycle spacing.
- Op 3'b110 issued:
  - With `DATAPATH_CTRL_TRAP_EN`: `err`=1, `done` never asserts, only reset recovers.
  - Without it: `done` pulses after 1 cycle, R0–R3 unchanged, `err`=0.
